// File: rtl/display_read_arbiter.sv
// display_read_arbiter
// Shares the memMux back-door read port between the display DMA (requester 0)
// and a second bulk reader (requester 1). Only one cache-line read is granted
// at a time. The owner of each in-flight read is kept in a tag FIFO, and each
// returning RDready beat is steered to the requester that issued the read.
//
// Build option: define DRA_STARVE_GUARD_EN to add the requester-1 starve
// counter. When requester 1 has waited MAX_WAIT cycles, it is given a forced
// grant. Without the macro there is no starve counter, and requester 1 is
// served only when dReadReq is low or during vertical front porch.
module display_read_arbiter #(
    parameter int BEATS    = 2,
    parameter int DEPTH    = 16,
    parameter int MAX_WAIT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        verticalFP,
    input  logic [25:0] dRA,
    input  logic        dReadReq,
    output logic        dReadAck,
    output logic        dRDready,
    input  logic [25:0] cRA,
    input  logic        cReadReq,
    output logic        cReadAck,
    output logic        cRDready,
    output logic [25:0] RA,
    output logic        readReq,
    input  logic        readAck,
    input  logic        RDready,
    output logic        orphan
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

    // Elaboration-time sanity on the configuration.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || BEATS < 1 || MAX_WAIT < 1) begin : g_bad_params
        $error("display_read_arbiter: DEPTH must be a power of 2 >= 2, BEATS and MAX_WAIT >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DEPTH-1:0] tag_q;
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic             orphan_q, orphan_d;

    logic             push, push_tag, pop;
    logic             full, have_tag, head, last_beat;
    logic             force_c;

    assign full     = (count_q == CW'(DEPTH));
    assign have_tag = (count_q != '0);
    assign head     = tag_q[rd_ptr_q];

`ifdef DRA_STARVE_GUARD_EN
    localparam int SW = $clog2(MAX_WAIT + 1);

    logic [SW-1:0] starve_q, starve_d;

    // Count how long requester 1 has been kept waiting; saturates at MAX_WAIT.
    always_comb begin
        starve_d = starve_q;
        if (!cReadReq || cReadAck) begin
            starve_d = '0;
        end else if (state_q != GNT1 && starve_q != SW'(MAX_WAIT)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // Starve counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign force_c = (starve_q == SW'(MAX_WAIT)) && cReadReq;
`else
    assign force_c = 1'b0;
`endif

    // Arbitration FSM: pick an owner in IDLE, drive the memMux port in GNTn.
    always_comb begin
        state_d  = state_q;
        readReq  = 1'b0;
        RA       = '0;
        dReadAck = 1'b0;
        cReadAck = 1'b0;
        push     = 1'b0;
        push_tag = 1'b0;
        case (state_q)
            IDLE: begin
                if (!full) begin
                    if (force_c) begin
                        state_d = GNT1;
                    end else if (verticalFP && cReadReq) begin
                        state_d = GNT1;
                    end else if (dReadReq) begin
                        state_d = GNT0;
                    end else if (cReadReq) begin
                        state_d = GNT1;
                    end
                end
            end
            GNT0: begin
                readReq = dReadReq;
                RA      = dRA;
                if (!dReadReq) begin
                    // Requester withdrew before the ack, so no read is outstanding.
                    state_d = IDLE;
                end else if (readAck) begin
                    dReadAck = 1'b1;
                    push     = 1'b1;
                    push_tag = 1'b0;
                    state_d  = IDLE;
                end
            end
            GNT1: begin
                readReq = cReadReq;
                RA      = cRA;
                if (!cReadReq) begin
                    state_d = IDLE;
                end else if (readAck) begin
                    cReadAck = 1'b1;
                    push     = 1'b1;
                    push_tag = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Route returning beats to the owner of the head tag.
    assign dRDready  = RDready & have_tag & ~head;
    assign cRDready  = RDready & have_tag & head;
    assign last_beat = RDready & have_tag & (beat_q == BW'(BEATS - 1));
    assign pop       = last_beat;

    // Beat counter, tag occupancy and sticky orphan flag.
    always_comb begin
        beat_d   = beat_q;
        count_d  = count_q;
        orphan_d = orphan_q;
        if (RDready && have_tag) begin
            beat_d = last_beat ? '0 : beat_q + BW'(1);
        end
        if (RDready && !have_tag) begin
            // A beat with no owner is dropped; the beat counter is left alone.
            orphan_d = 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Tag FIFO storage, pointers and counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            beat_q   <= '0;
            orphan_q <= 1'b0;
        end else begin
            if (push) begin
                tag_q[wr_ptr_q] <= push_tag;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q  <= count_d;
            beat_q   <= beat_d;
            orphan_q <= orphan_d;
        end
    end

    assign orphan = orphan_q;

endmodule

// File: doc/display_read_arbiter.md
# display_read_arbiter

Shares the memMux back-door read port between the display DMA (requester 0) and a second bulk reader, e.g. the block copier (requester 1). Grants one cache-line read at a time and tracks the owner of every in-flight request in a tag FIFO. Routes each returning RDready beat to the requester that issued it. Display reads have priority; requester 1 is favoured during vertical front porch and protected from starvation.

## Interface
- BEATS, 2: RDready beats returned per granted read (96-bit beats).
- DEPTH, 16: maximum outstanding reads; tag FIFO depth (power of 2).
- MAX_WAIT, 64: cycles requester 1 may wait before a forced grant.
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- verticalFP  in  1  display in vertical front porch.
- dRA  in  26  requester 0 cache-line address.
- dReadReq  in  1  requester 0 read request (level).
- dReadAck  out  1  requester 0 request accepted (1-cycle pulse).
- dRDready  out  1  beat on RD belongs to requester 0.
- cRA  in  26  requester 1 cache-line address.
- cReadReq  in  1  requester 1 read request (level).
- cReadAck  out  1  requester 1 request accepted (1-cycle pulse).
- cRDready  out  1  beat on RD belongs to requester 1.
- RA  out  26  address to memMux.
- readReq  out  1  request to memMux.
- readAck  in  1  memMux accepted request (1-cycle pulse).
- RDready  in  1  memMux returned beat (RD itself is broadcast; not routed here).
- orphan  out  1  sticky: RDready arrived with no outstanding tag.

## Operation
- FSM states IDLE, GNT0, GNT1; reset -> IDLE.
- IDLE: if tag count == DEPTH, stay. Otherwise pick, in order:
  - forced requester 1 (starve counter == MAX_WAIT and cReadReq);
  - requester 1 if verticalFP and cReadReq;
  - requester 0 if dReadReq;
  - requester 1 if cReadReq.
  - Go to GNT0/GNT1 next cycle; with no request, stay.
- GNTn: readReq = nReadReq (combinational); RA = nRA. On readAck, nReadAck = 1 in the same cycle, push tag n, and go to IDLE. If nReadReq drops before ack, readReq drops the same cycle and the FSM goes to IDLE next cycle; no tag is pushed.
- Only one grant at a time. Minimum one IDLE cycle between grants.
- Tag FIFO: 1-bit owner per entry. Count is 0..DEPTH, width clog2(DEPTH)+1.
- Beat counter 0..BEATS-1 advances on RDready. When RDready arrives with the count nonzero, route the beat to the owner of the head tag: xRDready = RDready & (head == x). On the last beat, pop the tag and clear the beat counter.
- Simultaneous push and pop: count unchanged; both take effect.
- RDready with count == 0: no xRDready asserted, orphan set, beat counter untouched. orphan clears only on reset.
- Starve counter: increments each cycle cReadReq is high and not in GNT1; clears on cReadAck or when cReadReq is low; saturates at MAX_WAIT.
- Reset mid-operation: FSM, tags, counters and orphan clear immediately. Beats from reads issued before reset arrive as orphans; the display DMA already discards stale reads with its own start-up wait.

## Timing
- Reset values: readReq 0, RA 0, dReadAck 0, cReadAck 0, dRDready 0, cRDready 0, orphan 0.
- Request to readReq: 2 cycles min. Cycle 1: IDLE samples the request. Cycle 2: GNTn drives readReq.
- readAck to nReadAck: 0 cycles (combinational).
- RDready to xRDready: 0 cycles (combinational from head tag).
- Throughput: one grant per 2 cycles plus memMux ack latency.

## Configuration
- DRA_STARVE_GUARD_EN defined: starve counter and forced-grant rule are built in.
- Undefined: the counter is not instantiated, and MAX_WAIT is ignored. Requester 1 is granted only when dReadReq is low, or when verticalFP is high.

## Test plan
- Priority: dReadReq=cReadReq=1, verticalFP=0, readAck 1 cycle after readReq -> RA=dRA each grant; cReadAck never asserted until forced grant (guard on) after 64 wait cycles.
- Front porch: both requests, verticalFP=1 -> first grant GNT1, RA=cRA, cReadAck pulse.
- Routing: issue d, c, d; return 6 RDready pulses -> dRDready on beats 1-2 and 5-6, cRDready on beats 3-4; count returns to 0.
- Full: 16 acked reads, no RDready -> readReq stays 0 with requests pending. One completed read (2 beats) -> next grant within 2 cycles.
- Withdraw: dReadReq drops in GNT0 before readAck -> readReq 0 the same cycle, no tag pushed, IDLE next cycle.
- Reset/orphan: assert reset with 3 reads outstanding, then 2 RDready -> no xRDready, orphan=1; assert reset again -> orphan=0.
